// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: consumer-side bundle of the UART receiver.
//   rx_data       - last good frame payload
//   data_ready    - unread frame held in rx_data
//   overrun_error - a committed frame overwrote unread data
//   framing_error - last frame had a 0 stop bit
//   receiving     - receiver is busy with a frame (not IDLE)
//   data_read     - consumer strobe acknowledging rx_data
// master: the receiver core; slave: the consumer.
interface uart_rx_core_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic [NUM_DATA_BITS-1:0] rx_data;
    logic                     data_ready;
    logic                     overrun_error;
    logic                     framing_error;
    logic                     receiving;
    logic                     data_read;

    modport master (
        output rx_data, data_ready, overrun_error, framing_error, receiving,
        input  data_read
    );

    modport slave (
        input  rx_data, data_ready, overrun_error, framing_error, receiving,
        output data_read
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: start-bit-qualified UART receiver with mid-bit sampling.
//   clk       - sole clock, rising edge
//   n_rst     - synchronous active-low reset
//   serial_in - asynchronous serial line, idle high
//   rx        - uart_rx_core_if.master: payload, status flags, data_read strobe
// Sample points are counted from T0, the first cycle the synchronized line
// is seen low after being high: start check at T0+CPB/2, then every CPB.
module uart_rx_core #(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10,
    parameter int SHIFT_MSB     = 0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             serial_in,
    uart_rx_core_if.master   rx
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START_CHK, DATA, STOP, COMMIT} state_t;

    state_t                   state, state_next;
    logic                     sync_a, sync, edge_q;
    logic [TW-1:0]            timer;
    logic [CW-1:0]            bit_cnt;
    logic [NUM_DATA_BITS-1:0] shreg, shreg_shifted;
    logic [NUM_DATA_BITS-1:0] rx_data;
    logic                     data_ready, overrun_error, framing_error, receiving;
    logic                     timer_clr, take_bit, stop_bad;

    wire start_edge = !sync && edge_q;

    // New bit enters at the end that places the first bit where SHIFT_MSB asks.
    if (NUM_DATA_BITS == 1) begin : g_one
        assign shreg_shifted = sync;
    end else if (SHIFT_MSB != 0) begin : g_msb
        assign shreg_shifted = {shreg[NUM_DATA_BITS-2:0], sync};
    end else begin : g_lsb
        assign shreg_shifted = {sync, shreg[NUM_DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        take_bit   = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (start_edge) state_next = START_CHK;
            end
            START_CHK: begin
                if (timer == HALF_END) begin
                    timer_clr  = 1'b1;
                    state_next = sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == BIT_END) begin
                    timer_clr = 1'b1;
                    take_bit  = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (timer == BIT_END) begin
                    timer_clr  = 1'b1;
                    stop_bad   = !sync;
                    state_next = sync ? COMMIT : IDLE;
                end
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_a        <= 1'b1;
            sync          <= 1'b1;
            edge_q        <= 1'b1;
            timer         <= '0;
            bit_cnt       <= '0;
            shreg         <= '1;
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
            receiving     <= 1'b0;
        end else begin
            sync_a    <= serial_in;
            sync      <= sync_a;
            edge_q    <= sync;
            timer     <= timer_clr ? '0 : timer + 1'b1;
            receiving <= (state_next != IDLE);

            if (state != DATA)  bit_cnt <= '0;
            else if (take_bit)  bit_cnt <= bit_cnt + 1'b1;
            if (take_bit)       shreg   <= shreg_shifted;

            if (state == IDLE && start_edge) framing_error <= 1'b0;
            else if (stop_bad)               framing_error <= 1'b1;

            // A read landing in the commit cycle consumes the old frame.
            if (state == COMMIT) begin
                rx_data       <= shreg;
                data_ready    <= 1'b1;
                overrun_error <= data_ready && !rx.data_read;
            end else if (rx.data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

    assign rx.rx_data       = rx_data;
    assign rx.data_ready    = data_ready;
    assign rx.overrun_error = overrun_error;
    assign rx.framing_error = framing_error;
    assign rx.receiving     = receiving;
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter NUM_DATA_BITS, default 8, data bits per frame (legal range 1-16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10, clock cycles per bit period (legal range 4-1023).
REQ-003 SHALL have parameter SHIFT_MSB, default 0; 0 means the first received data bit is rx_data[0], 1 means it is rx_data[NUM_DATA_BITS-1].
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port serial_in  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port data_read  input  1  consumer strobe acknowledging rx_data.
REQ-008 SHALL have port rx_data  output  NUM_DATA_BITS  last good frame payload (registered).
REQ-009 SHALL have port data_ready  output  1  unread frame held in rx_data (registered).
REQ-010 SHALL have port overrun_error  output  1  a committed frame overwrote unread data (registered).
REQ-011 SHALL have port framing_error  output  1  last frame had stop bit 0 (registered).
REQ-012 SHALL have port receiving  output  1  high in every FSM state except IDLE (registered).

Function
REQ-013 SHALL pass serial_in through a 2-flop synchronizer, then one further edge-detect flop; all sampling uses the synchronizer output (sync).
REQ-014 SHALL define T0 as the cycle in which sync is 0 while the edge-detect flop is 1; a start is detected only in IDLE and only at T0.
REQ-015 SHALL implement FSM states IDLE, START_CHK, DATA, STOP, COMMIT.
REQ-016 SHALL on T0 in IDLE go to START_CHK, clear the bit timer, clear framing_error.
REQ-017 SHALL in START_CHK sample sync at T0+floor(CLKS_PER_BIT/2); 1 -> false start, return to IDLE, no output change; 0 -> DATA.
REQ-018 SHALL in DATA sample data bit k (k=0..NUM_DATA_BITS-1) at T0+floor(CLKS_PER_BIT/2)+(k+1)*CLKS_PER_BIT, shifting it into an internal shift register per SHIFT_MSB.
REQ-019 SHALL after the last data sample go to STOP and sample stop bit at T0+floor(CLKS_PER_BIT/2)+(NUM_DATA_BITS+1)*CLKS_PER_BIT.
REQ-020 SHALL on stop bit 1 go to COMMIT; next edge: rx_data <= shift register, data_ready <= 1, then IDLE.
REQ-021 SHALL on stop bit 0 set framing_error on the next edge, leave rx_data/data_ready/overrun_error unchanged, return to IDLE.
REQ-022 SHALL set overrun_error at COMMIT if data_ready is 1 and data_read is 0 in that cycle; new data still overwrites rx_data.
REQ-023 SHALL on data_read=1 (not in COMMIT cycle) clear data_ready and overrun_error on the next edge; data_read with data_ready=0 has no effect.
REQ-024 SHALL treat data_read=1 in the COMMIT cycle as consuming old data: result data_ready=1, overrun_error=0.
REQ-025 SHALL, after a framing error with line held low, not restart until sync returns to 1 and falls again (edge-triggered only).
REQ-026 SHALL ignore line glitches in DATA/STOP; only the scheduled samples matter.
REQ-027 SHALL size the bit timer ceil(log2(CLKS_PER_BIT)) bits and bit counter ceil(log2(NUM_DATA_BITS+1)) bits; no wrap within a frame.

Reset
REQ-028 SHALL when n_rst=0 at a rising clk edge: FSM=IDLE, synchronizer and edge flops=1, shift register=all 1s, rx_data=all 1s, data_ready=0, overrun_error=0, framing_error=0, receiving=0.
REQ-029 SHALL abort any frame in progress on reset with no partial commit; reception resumes only on a fresh falling edge after reset release.

Verification
REQ-030 SHALL cover good frame: defaults, send 0xA5 LSB-first with stop 1 -> rx_data=0xA5, data_ready=1, errors 0, receiving low after COMMIT.
REQ-031 SHALL cover false start: low pulse 3 clocks wide -> return to IDLE, data_ready=0, rx_data=0xFF, framing_error=0.
REQ-032 SHALL cover framing error: 0x3C with stop bit 0 -> framing_error=1, rx_data=0xFF, data_ready=0; next good 0x11 clears framing_error at its start.
REQ-033 SHALL cover overrun: 0x55 then 0xAA without data_read -> rx_data=0xAA, data_ready=1, overrun_error=1; data_read pulse -> both 0.
REQ-034 SHALL cover read-at-commit: data_read asserted in COMMIT cycle of second frame 0x0F -> rx_data=0x0F, data_ready=1, overrun_error=0.
REQ-035 SHALL cover mid-frame reset and SHIFT_MSB=1: reset during bit 4 -> all outputs at reset values, no commit; with SHIFT_MSB=1 sending bits 1,0,1,0,0,1,0,1 -> rx_data=0xA5.
